// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the link FIFO write port between NUM_REQ byte
// producers; each grant is capped at MAX_BURST accepted bytes.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  parameter int DATA_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      full,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      wr_fifo,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_reg, state_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [PTR_W-1:0]   gidx_reg, gidx_next;
  logic [3:0]         burst_cnt_reg, burst_cnt_next;
  logic               busy_reg, busy_next;

  logic [PTR_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_req;
  logic [NUM_REQ-1:0] win_onehot;
  logic [PTR_W-1:0]   win_idx;
  logic               win_valid;
  logic [DATA_W-1:0]  slice_data [NUM_REQ];
  logic               req_g;
  logic [PTR_W-1:0]   after_g;

  // Candidate k is requester (rr_ptr + k) mod NUM_REQ; k = 0 has top priority.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [PTR_W:0] sum;
      assign sum          = {1'b0, rr_ptr_reg} + (PTR_W+1)'(gi);
      assign cand_idx[gi] = (sum >= (PTR_W+1)'(NUM_REQ)) ?
                            PTR_W'(sum - (PTR_W+1)'(NUM_REQ)) : PTR_W'(sum);
      assign cand_req[gi] = req[cand_idx[gi]];
      assign win_onehot[gi] = (win_idx == PTR_W'(gi));
    end
  endgenerate

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        win_valid = 1'b1;
        win_idx   = cand_idx[k];
      end
    end
  end

  // Grant is only non-zero in GRANT, so these AND-OR terms also force idle zeros.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
      assign ack[gi]        = grant_reg[gi] & req[gi] & ~full;
      assign slice_data[gi] = grant_reg[gi] ? req_data[gi*DATA_W +: DATA_W] : '0;
    end
  endgenerate

  always_comb begin
    wr_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      wr_data = wr_data | slice_data[k];
    end
  end

  assign wr_fifo = |ack;
  assign grant   = grant_reg;
  assign busy    = busy_reg;
  assign req_g   = |(grant_reg & req);
  assign after_g = (gidx_reg == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_reg + 1'b1;

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    rr_ptr_next    = rr_ptr_reg;
    gidx_next      = gidx_reg;
    burst_cnt_next = burst_cnt_reg;
    busy_next      = busy_reg;
    case (state_reg)
      IDLE: begin
        if (win_valid) begin
          state_next     = GRANT;
          grant_next     = win_onehot;
          gidx_next      = win_idx;
          burst_cnt_next = '0;
          busy_next      = 1'b1;
        end
      end
      GRANT: begin
        // Releasing req or exhausting the burst both hand priority to g+1.
        if (!req_g || (wr_fifo && burst_cnt_reg == 4'(MAX_BURST - 1))) begin
          state_next  = IDLE;
          grant_next  = '0;
          busy_next   = 1'b0;
          rr_ptr_next = after_g;
        end else if (wr_fifo) begin
          burst_cnt_next = burst_cnt_reg + 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      rr_ptr_reg    <= '0;
      gidx_reg      <= '0;
      burst_cnt_reg <= '0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      rr_ptr_reg    <= rr_ptr_next;
      gidx_reg      <= gidx_next;
      burst_cnt_reg <= burst_cnt_next;
      busy_reg      <= busy_next;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares the single write port of the link FIFO (wr_fifo/wr_data, back-pressured by full) between NUM_REQ byte producers. It grants one producer at a time for a bounded burst, so no producer can monopolise the serial link. It sits upstream of the FIFO and feeds it directly. The serializer/deserializer path is unchanged.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_BURST, 4, max bytes accepted per grant before priority rotates (1..15)
DATA_W, 8, byte width, matches FIFO wr_data

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
req  input  NUM_REQ  per-requester "byte available", held until acked
req_data  input  NUM_REQ*DATA_W  flattened bytes, requester i at bits [i*DATA_W +: DATA_W]
full  input  1  FIFO full, from FIFO
ack  output  NUM_REQ  byte of requester i accepted this cycle (combinational)
grant  output  NUM_REQ  one-hot registered grant, all-zero when idle
wr_fifo  output  1  FIFO write strobe (combinational, = |ack)
wr_data  output  DATA_W  byte of granted requester, 0 when no grant
busy  output  1  registered, 1 while in GRANT state

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE, grant=0, busy=0, rr_ptr=0, burst_cnt=0. ack, wr_fifo and wr_data are therefore 0. Reset mid-burst drops the grant with no further write. A requester whose byte was not acked keeps req high and is re-arbitrated.
- States: IDLE, GRANT.
- IDLE: if |req, select the first asserted req scanning rr_ptr, rr_ptr+1, … mod NUM_REQ. Next cycle: grant one-hot on the winner, busy=1, burst_cnt=0, state=GRANT. If no req, stay in IDLE.
- GRANT, winner g:
  - ack[g] = req[g] & ~full. All other ack bits are 0. wr_fifo = ack[g]. wr_data = req_data slice g.
  - On ack, burst_cnt++.
- GRANT exit: move to IDLE next cycle, with grant=0, busy=0, rr_ptr=(g+1) mod NUM_REQ, when either:
  - ack occurs with burst_cnt==MAX_BURST-1, so exactly MAX_BURST bytes are written; or
  - req[g]==0 in a GRANT cycle. No write happens in that cycle.
- full while granted: hold the grant with no ack and no count change, indefinitely. Full-stall cycles do not consume burst budget.
- Latency: req rising in IDLE gives the first possible ack 1 cycle later. The re-arbitration gap is exactly 1 IDLE cycle between grants.
- Back-to-back grants to the same requester are allowed only when no other req is asserted at the IDLE sample.
- wr_data is never X: it is 0 when grant==0.
- Invariants:
  - grant is zero or one-hot.
  - ack is a subset of grant.
  - wr_fifo is never 1 while full=1.
  - Per grant: ack count <= MAX_BURST.
- Requester protocol: req_data[i] must be stable while req[i]=1 and not acked. Producers update req_data on the cycle following ack.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with req=4'b1111 -> grant=0, wr_fifo=0, busy=0. After release, the first grant is 4'b0001.
- Single requester: req[2]=1 continuously, data 0x10,0x11,… updated after each ack, full=0 -> grant=4'b0100 one cycle after req; 4 consecutive writes 0x10..0x13; 1 idle cycle; regrant to req2.
- Round robin: req=4'b1111 for 40 cycles, full=0 -> grant order 0,1,2,3,0…; each grant gives 4 writes then 1 gap cycle; 32 writes total in 40 cycles.
- Back-pressure: req[1] granted, full=1 for cycles 2–6 of the burst -> no wr_fifo and no ack during full. The burst still completes with exactly 4 writes, and data order is preserved.
- Early release: req[3] drops after 2 acks -> grant returns to 0 one cycle later. rr_ptr becomes 0, so the next winner with req=4'b1001 is requester 0.
- Mid-burst reset: reset after 2 of 4 writes for req0 -> grant=0 next cycle. After reset, req0 regains the grant and the bench scoreboard sees no duplicated or lost bytes.
